// File: rtl/nn_mac_accum.sv
// nn_mac_accum -- accumulates a group of unsigned products and emits one
// requantized result per group.
//
// A group is cfg_len products long (0 counts as 1). The first product of a
// group latches cfg_len/cfg_bias/cfg_shift and starts the sum at
// cfg_bias + product. Additions saturate at 2^ACC_W-1. When the group
// closes, (acc >> shift) is clipped to OUT_W bits and registered, together
// with a saturation flag, onto the output stream.
//
// Optional feature: define NN_ACC_ROUND_EN to round half-up before the
// shift; otherwise the result is truncated.
//
// Ports:
//   ap_clk, ap_rst              clock, asynchronous active-high reset
//   cfg_len, cfg_bias, cfg_shift group configuration (sampled on first product)
//   prod_dat, prod_vld, prod_rdy product stream (input)
//   out_dat, out_vld, out_rdy    result stream (output)
//   out_sat                      result clipped or accumulator saturated
//   busy                         high whenever a group is in progress

module nn_mac_accum #(
  parameter int PROD_W = 23,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 12
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ACC_W-1:0]  cfg_bias,
  input  logic [4:0]        cfg_shift,
  input  logic [PROD_W-1:0] prod_dat,
  input  logic              prod_vld,
  output logic              prod_rdy,
  output logic [OUT_W-1:0]  out_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_sat,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] OUT_MAX  = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  // Saturating unsigned add; MSB of the result is the saturation indicator.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = {1'b0, sum[ACC_W-1:0]};
    end
  endfunction

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [LEN_W-1:0] count_r;
  logic [LEN_W-1:0] len_r;
  logic [4:0]       shift_r;
  logic             flag_r;

  logic             xfer_in_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [LEN_W-1:0] len_eff_s;
  logic [LEN_W-1:0] count_inc_s;
  logic [ACC_W-1:0] add_a_s;
  logic [ACC_W:0]   add_s;
  logic [ACC_W-1:0] shifted_s;
  logic             pre_sat_s;
  logic             clip_s;
  logic [OUT_W-1:0] res_s;

  assign xfer_in_s   = prod_vld & prod_rdy;
  assign prod_ext_s  = {{(ACC_W-PROD_W){1'b0}}, prod_dat};
  assign count_inc_s = count_r + LEN_ONE;

  // Effective group length and the accumulator adder (bias on the first product).
  always_comb begin
    len_eff_s = cfg_len;
    add_a_s   = acc_r;
    if (cfg_len == LEN_ZERO) begin
      len_eff_s = LEN_ONE;
    end else begin
      len_eff_s = cfg_len;
    end
    if (state_r == IDLE) begin
      add_a_s = cfg_bias;
    end else begin
      add_a_s = acc_r;
    end
    add_s = sat_add(add_a_s, prod_ext_s);
  end

`ifdef NN_ACC_ROUND_EN
  localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
  logic [ACC_W-1:0] rnd_s;
  logic [ACC_W:0]   rnd_sum_s;

  // Round half-up: add 2^(shift-1) (nothing when shift is 0), saturating.
  always_comb begin
    rnd_s = ACC_ZERO;
    if (shift_r == 5'd0) begin
      rnd_s = ACC_ZERO;
    end else begin
      rnd_s = ACC_ONE << (shift_r - 5'd1);
    end
    rnd_sum_s = sat_add(acc_r, rnd_s);
    shifted_s = rnd_sum_s[ACC_W-1:0] >> shift_r;
    pre_sat_s = rnd_sum_s[ACC_W];
  end
`else
  // Truncating requantization.
  always_comb begin
    shifted_s = acc_r >> shift_r;
    pre_sat_s = 1'b0;
  end
`endif

  // Clip the shifted sum to the output width.
  always_comb begin
    res_s  = shifted_s[OUT_W-1:0];
    clip_s = 1'b0;
    if (shifted_s > OUT_MAX) begin
      res_s  = {OUT_W{1'b1}};
      clip_s = 1'b1;
    end else begin
      res_s  = shifted_s[OUT_W-1:0];
      clip_s = 1'b0;
    end
  end

  // Group control FSM with registered handshake and result outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r  <= IDLE;
      acc_r    <= ACC_ZERO;
      count_r  <= LEN_ZERO;
      len_r    <= LEN_ONE;
      shift_r  <= 5'd0;
      flag_r   <= 1'b0;
      out_dat  <= {OUT_W{1'b0}};
      out_vld  <= 1'b0;
      out_sat  <= 1'b0;
      busy     <= 1'b0;
      prod_rdy <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_in_s) begin
            len_r   <= len_eff_s;
            shift_r <= cfg_shift;
            acc_r   <= add_s[ACC_W-1:0];
            flag_r  <= add_s[ACC_W];
            count_r <= LEN_ONE;
            busy    <= 1'b1;
            if (len_eff_s == LEN_ONE) begin
              state_r  <= OUT;
              prod_rdy <= 1'b0;
            end else begin
              state_r  <= ACC;
              prod_rdy <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACC: begin
          if (xfer_in_s) begin
            acc_r   <= add_s[ACC_W-1:0];
            flag_r  <= flag_r | add_s[ACC_W];
            count_r <= count_inc_s;
            if (count_inc_s == len_r) begin
              state_r  <= OUT;
              prod_rdy <= 1'b0;
            end else begin
              state_r  <= ACC;
            end
          end else begin
            state_r <= ACC;
          end
        end
        OUT: begin
          // First OUT cycle registers the result; afterwards hold until taken.
          if (!out_vld) begin
            out_dat <= res_s;
            out_sat <= flag_r | pre_sat_s | clip_s;
            out_vld <= 1'b1;
          end else if (out_rdy) begin
            out_vld  <= 1'b0;
            out_sat  <= 1'b0;
            flag_r   <= 1'b0;
            acc_r    <= ACC_ZERO;
            count_r  <= LEN_ZERO;
            state_r  <= IDLE;
            busy     <= 1'b0;
            prod_rdy <= 1'b1;
          end else begin
            state_r <= OUT;
          end
        end
        default: begin
          state_r  <= IDLE;
          acc_r    <= ACC_ZERO;
          count_r  <= LEN_ZERO;
          flag_r   <= 1'b0;
          out_vld  <= 1'b0;
          out_sat  <= 1'b0;
          busy     <= 1'b0;
          prod_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_accum.sv
module tb_nn_mac_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [11:0] cfg_len = 12'd1;
  logic [31:0] cfg_bias = 32'd0;
  logic [4:0]  cfg_shift = 5'd0;
  logic [22:0] prod_dat = 23'd0;
  logic        prod_vld = 1'b0;
  logic        prod_rdy;
  logic [15:0] out_dat;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic        out_sat;
  logic        busy;

  int tests = 0;
  int fails = 0;

  nn_mac_accum dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cfg_len(cfg_len), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .prod_dat(prod_dat), .prod_vld(prod_vld), .prod_rdy(prod_rdy),
    .out_dat(out_dat), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [11:0]      len;
    logic [31:0]      bias;
    logic [4:0]       shift;
    int               n;
    logic [7:0][22:0] p;
    bit               gap;
    logic [15:0]      exp_dat;
    logic             exp_sat;
  } vec_t;

`ifdef NN_ACC_ROUND_EN
  localparam logic [15:0] EXP_SH2 = 16'd2;
  localparam logic [15:0] EXP_SH1 = 16'd4;
`else
  localparam logic [15:0] EXP_SH2 = 16'd1;
  localparam logic [15:0] EXP_SH1 = 16'd3;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one product and wait (bounded) until it is accepted.
  task automatic push(input logic [22:0] p, output int waited);
    waited = 0;
    prod_dat = p;
    prod_vld = 1'b1;
    while (!prod_rdy && waited < 50) begin
      @(negedge ap_clk);
      waited++;
    end
    if (waited >= 50) check("push_timeout", 32'd1, 32'd0);
    @(posedge ap_clk);
    #1;
    prod_vld = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w;
    cfg_len = v.len;
    cfg_bias = v.bias;
    cfg_shift = v.shift;
    for (int i = 0; i < v.n; i++) begin
      if (v.gap && i > 0) repeat (2) @(negedge ap_clk);
      push(v.p[i], w);
      if (i == 0) begin
        // Config must be ignored after the first product.
        cfg_len = v.len + 12'd2;
        cfg_bias = 32'hDEAD_BEEF;
        cfg_shift = 5'd7;
      end
      if (i < v.n - 1) begin
        check($sformatf("v%0d_mid_rdy%0d", idx, i), {31'd0, prod_rdy}, 32'd1);
        check($sformatf("v%0d_mid_vld%0d", idx, i), {31'd0, out_vld}, 32'd0);
      end
    end
    check($sformatf("v%0d_vld_early", idx), {31'd0, out_vld}, 32'd0);
    check($sformatf("v%0d_rdy_low", idx), {31'd0, prod_rdy}, 32'd0);
    check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
    @(posedge ap_clk);
    #1;
    check($sformatf("v%0d_vld", idx), {31'd0, out_vld}, 32'd1);
    check($sformatf("v%0d_dat", idx), {16'd0, out_dat}, {16'd0, v.exp_dat});
    check($sformatf("v%0d_sat", idx), {31'd0, out_sat}, {31'd0, v.exp_sat});
    out_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    out_rdy = 1'b0;
    check($sformatf("v%0d_vld_clr", idx), {31'd0, out_vld}, 32'd0);
    check($sformatf("v%0d_idle", idx), {31'd0, busy}, 32'd0);
    cfg_len = 12'd1;
  endtask

  function automatic vec_t mk(input logic [11:0] len, input logic [31:0] bias,
                              input logic [4:0] shift, input int n, input bit gap,
                              input logic [22:0] p0, input logic [22:0] p1,
                              input logic [22:0] p2, input logic [22:0] p3,
                              input logic [22:0] p4,
                              input logic [15:0] ed, input logic es);
    vec_t v;
    v.len = len; v.bias = bias; v.shift = shift; v.n = n; v.gap = gap;
    v.p = '0;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3; v.p[4] = p4;
    v.exp_dat = ed; v.exp_sat = es;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    int w;
    vecs[0]  = mk(12'd4, 32'd0, 5'd0, 4, 1'b0, 23'd1, 23'd2, 23'd3, 23'd4, 23'd0, 16'd10, 1'b0);
    vecs[1]  = mk(12'd2, 32'd0, 5'd0, 2, 1'b0, 23'h7FFFFF, 23'h7FFFFF, 23'd0, 23'd0, 23'd0, 16'hFFFF, 1'b1);
    vecs[2]  = mk(12'd2, 32'd0, 5'd2, 2, 1'b0, 23'd3, 23'd3, 23'd0, 23'd0, 23'd0, EXP_SH2, 1'b0);
    vecs[3]  = mk(12'd1, 32'd100, 5'd0, 1, 1'b0, 23'd5, 23'd0, 23'd0, 23'd0, 23'd0, 16'd105, 1'b0);
    vecs[4]  = mk(12'd0, 32'd0, 5'd0, 1, 1'b0, 23'd7, 23'd0, 23'd0, 23'd0, 23'd0, 16'd7, 1'b0);
    vecs[5]  = mk(12'd1, 32'hFFFF_FFF0, 5'd16, 1, 1'b0, 23'h20, 23'd0, 23'd0, 23'd0, 23'd0, 16'hFFFF, 1'b1);
    vecs[6]  = mk(12'd3, 32'h0001_0000, 5'd4, 3, 1'b1, 23'h100, 23'h200, 23'h300, 23'd0, 23'd0, 16'h1060, 1'b0);
    vecs[7]  = mk(12'd5, 32'd0, 5'd0, 5, 1'b1, 23'd1, 23'd1, 23'd1, 23'd1, 23'd1, 16'd5, 1'b0);
    vecs[8]  = mk(12'd2, 32'd0, 5'd1, 2, 1'b0, 23'd3, 23'd4, 23'd0, 23'd0, 23'd0, EXP_SH1, 1'b0);
    vecs[9]  = mk(12'd1, 32'd0, 5'd0, 1, 1'b0, 23'hFFFF, 23'd0, 23'd0, 23'd0, 23'd0, 16'hFFFF, 1'b0);
    vecs[10] = mk(12'd1, 32'd0, 5'd0, 1, 1'b0, 23'h10000, 23'd0, 23'd0, 23'd0, 23'd0, 16'hFFFF, 1'b1);

    // Reset state.
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_vld", {31'd0, out_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dat", {16'd0, out_dat}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("rst_rdy", {31'd0, prod_rdy}, 32'd1);

    // Table: vec 6 (len 3, cfg_len scrambled to 5 mid-group) then vec 7 uses len 5.
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-pressure with len 1: output held for 5 cycles.
    cfg_len = 12'd1; cfg_bias = 32'd0; cfg_shift = 5'd0;
    push(23'd9, w);
    @(posedge ap_clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_vld%0d", c), {31'd0, out_vld}, 32'd1);
      check($sformatf("bp_rdy%0d", c), {31'd0, prod_rdy}, 32'd0);
      check($sformatf("bp_dat%0d", c), {16'd0, out_dat}, 32'd9);
      @(posedge ap_clk);
      #1;
    end
    out_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    out_rdy = 1'b0;
    check("bp_taken", {31'd0, out_vld}, 32'd0);
    push(23'd11, w);
    check("bp_next_wait", w, 32'd0);
    @(posedge ap_clk);
    #1;
    check("bp_next_dat", {16'd0, out_dat}, 32'd11);
    out_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    out_rdy = 1'b0;

    // Reset mid-group discards the partial sum.
    cfg_len = 12'd4; cfg_bias = 32'd0; cfg_shift = 5'd0;
    push(23'd100, w);
    push(23'd200, w);
    ap_rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    vecs[0] = mk(12'd4, 32'd0, 5'd0, 4, 1'b0, 23'd5, 23'd5, 23'd5, 23'd5, 23'd0, 16'd20, 1'b0);
    run_vec(vecs[0], 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nn_mac_accum.md
NN_MAC_ACCUM -- requirements
Module: nn_mac_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 23, width of unsigned product input (multiplier output).
REQ-002 SHALL have parameter ACC_W, default 32, width of unsigned internal accumulator.
REQ-003 SHALL have parameter OUT_W, default 16, width of unsigned requantized result.
REQ-004 SHALL have parameter LEN_W, default 12, width of group-length config.
REQ-005 SHALL have port ap_clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port ap_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cfg_len, input, LEN_W, products per output group; value 0 treated as 1.
REQ-008 SHALL have port cfg_bias, input, ACC_W, unsigned bias preloaded into accumulator.
REQ-009 SHALL have port cfg_shift, input, 5, right-shift applied to final sum.
REQ-010 SHALL have ports prod_dat (input, PROD_W), prod_vld (input, 1), prod_rdy (output, 1), the product stream.
REQ-011 SHALL have ports out_dat (output, OUT_W), out_vld (output, 1), out_rdy (input, 1), the result stream.
REQ-012 SHALL have port out_sat, output, 1, qualified by out_vld: result clipped or accumulator saturated.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL transfer a product when prod_vld and prod_rdy are both high at a rising edge; same rule for outputs with out_vld/out_rdy.
REQ-015 SHALL implement states IDLE, ACC, OUT; prod_rdy high in IDLE and ACC, low in OUT.
REQ-016 IDLE: on product transfer, latch cfg_len/cfg_bias/cfg_shift, set acc = cfg_bias + prod_dat, count = 1; go to ACC, or directly to OUT if latched length is 1.
REQ-017 ACC: on each transfer, acc += prod_dat and count += 1; when count reaches the latched length, go to OUT; cycles without prod_vld hold all state.
REQ-018 Config inputs SHALL be ignored except at the first product of a group.
REQ-019 Accumulator addition SHALL saturate at 2^ACC_W-1 and set a sticky group saturation flag.
REQ-020 Result SHALL be acc >> shift, clipped to 2^OUT_W-1 if larger (clip sets saturation flag), registered into out_dat together with out_sat.
REQ-021 Latency: the last product transferred at edge t SHALL produce out_vld high after edge t+1 (one register stage).
REQ-022 OUT: out_vld high and out_dat/out_sat stable until transfer; on transfer, return to IDLE and clear the flag; next product may transfer the following cycle.
REQ-023 out_vld SHALL be low in IDLE and ACC.
REQ-024 Count SHALL be LEN_W bits and never wrap; maximum group length 2^LEN_W-1.

Reset
REQ-025 ap_rst high SHALL immediately force state IDLE, acc 0, count 0, flag 0, out_dat 0, out_vld 0, out_sat 0, busy 0; prod_rdy SHALL be 1 after deassertion.
REQ-026 Reset mid-group SHALL discard partial sums; the first product after release starts a new group.

Configuration
REQ-027 Macro NN_ACC_ROUND_EN defined: the result SHALL be (acc + 2^(shift-1)) >> shift (round-half-up, no rounding when shift=0), with the addition saturating.
REQ-028 Macro NN_ACC_ROUND_EN undefined: the result SHALL be truncated (acc >> shift), with no rounding logic.

Verification
REQ-029 len=4, bias=0, shift=0, products 1,2,3,4 back-to-back, out_rdy=1 -> out_dat=10, out_sat=0, out_vld one cycle after 4th transfer.
REQ-030 len=2, bias=0, shift=0, products 0x7FFFFF,0x7FFFFF -> out_dat=0xFFFF, out_sat=1.
REQ-031 len=1, out_rdy held low 5 cycles -> prod_rdy low and out_dat stable for 5 cycles; transfer on cycle 6; next group accepted on cycle 7.
REQ-032 len=4, 2 products then ap_rst pulse, then products 5,5,5,5 -> out_dat=20 (partial sum discarded).
REQ-033 len=2, bias=0, shift=2, products 3,3 -> out_dat=1 without NN_ACC_ROUND_EN, 2 with it.
REQ-034 cfg_len changed 3->5 mid-group -> the current group still closes after 3 products; the next group uses 5.
